// File: rtl/board_scan_sequencer.sv
// Board scan sequencer: walks the board in row-major order, reads each cell
// from board memory and hands one box request per cell to the box drawer,
// waiting for its ack before moving on.
module board_scan_sequencer #(
  parameter int GRID_SIZE = 8,
  parameter int CELL_PX   = 8,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0,
  parameter int ADDR_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic [1:0]        cell_state,
  output logic              box_req,
  input  logic              box_ack,
  output logic [7:0]        box_x,
  output logic [6:0]        box_y,
  output logic [2:0]        box_colour
);

  localparam int CNT_W = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GRID_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    REQ,
    NEXT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             last_cell;
  logic [2:0]       colour_next;

  assign last_cell = (row == LAST) && (col == LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign box_req   = (state == REQ);
  assign cell_addr = ADDR_W'(row) * ADDR_W'(GRID_SIZE) + ADDR_W'(col);

  // State register; reset aborts any scan in progress straight back to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one fetch wait, one latch, hold REQ until ack, then step.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = REQ;
      REQ:     if (box_ack) state_next = NEXT;
      NEXT:    state_next = last_cell ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row/column walk; wraps back to cell 0 after the last cell so the address idles at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (state == NEXT) begin
      if (last_cell) begin
        row <= '0;
        col <= '0;
      end else if (col == LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Map the cell state read from memory onto its display colour.
  always_comb begin
    colour_next = 3'b111;
    case (cell_state)
      2'b00: colour_next = 3'b111;
      2'b01: colour_next = 3'b010;
      2'b10: colour_next = 3'b100;
      2'b11: colour_next = 3'b101;
      default: colour_next = 3'b111;
    endcase
  end

  // Box geometry and colour are loaded once per cell and held until the next cell.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      box_x      <= '0;
      box_y      <= '0;
      box_colour <= '0;
    end else if (state == LATCH) begin
      box_x      <= 8'(ORIGIN_X) + 8'(col) * 8'(CELL_PX);
      box_y      <= 7'(ORIGIN_Y) + 7'(row) * 7'(CELL_PX);
      box_colour <= colour_next;
    end
  end

endmodule
